// File: rtl/srt4_control.sv
// Slot-based sequencer for the radix-4 SRT divider datapath; every output is a flop.
// Optional divide-by-zero early exit is enabled by defining SRT4_DIV_ZERO_EN.
module srt4_control #(
  parameter int ITERS  = 4,
  parameter int NCNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic       b_msb,
  input  logic       b_zero,
  input  logic [2:0] p_est,
  input  logic       p_sign,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       c5,
  output logic       c6,
  output logic       c7,
  output logic       c8,
  output logic       c9,
  output logic       c10,
  output logic       c11,
  output logic       c12,
  output logic       c13,
  output logic       c14,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT_P, S_INIT_G, S_NORM_P, S_NORM_G, S_SHIFT_P, S_SHIFT_G,
    S_ADD_P, S_ADD_G, S_CORR_P, S_CORR_G, S_CONV_P, S_CONV_G,
    S_DEN_P, S_DEN_G, S_ZERO_P, S_ZERO_G, S_DONE
  } state_t;

  typedef enum logic [2:0] {D_ZERO, D_P1, D_P2, D_M1, D_M2} digit_t;

  state_t            state_reg, state_next;
  digit_t            dig_reg, dig_next, est_digit;
  logic [14:0]       c_reg, c_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [NCNT_W-1:0] n_reg, n_next;
  logic [IW-1:0]     iter_reg, iter_next;
  logic              enter_norm, enter_shift, enter_tail;
  logic              norm_more, add_sub, add_2b;

  function automatic digit_t decode_digit(input logic [2:0] e);
    case (e)
      3'b001:         return D_P1;
      3'b010, 3'b011: return D_P2;
      3'b110:         return D_M1;
      3'b100, 3'b101: return D_M2;
      default:        return D_ZERO;
    endcase
  endfunction

  assign est_digit = decode_digit(p_est);
  assign norm_more = !b_msb && (n_reg != {NCNT_W{1'b1}});
  // Adder levels for the ADD slot, derived from the digit stored at SHIFT.
  assign add_sub   = (dig_reg == D_P1) || (dig_reg == D_P2);
  assign add_2b    = (dig_reg == D_P2) || (dig_reg == D_M2);

`ifndef SRT4_DIV_ZERO_EN
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg <= S_IDLE;
      dig_reg   <= D_ZERO;
      c_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      n_reg     <= '0;
      iter_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dig_reg   <= dig_next;
      c_reg     <= c_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      n_reg     <= n_next;
      iter_reg  <= iter_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    dig_next    = dig_reg;
    c_next      = '0;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    err_next    = err_reg;
    n_next      = n_reg;
    iter_next   = iter_reg;
    enter_norm  = 1'b0;
    enter_shift = 1'b0;
    enter_tail  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_INIT_P;
          c_next[0]  = 1'b1;
          c_next[1]  = 1'b1;
          busy_next  = 1'b1;
          err_next   = 1'b0;
          n_next     = '0;
          iter_next  = '0;
          dig_next   = D_ZERO;
        end
      end
      S_INIT_P: state_next = S_INIT_G;
      S_INIT_G: begin
`ifdef SRT4_DIV_ZERO_EN
        if (b_zero) state_next = S_ZERO_P;
        else        enter_norm = 1'b1;
`else
        enter_norm = 1'b1;
`endif
      end
      S_NORM_P: state_next = S_NORM_G;
      S_NORM_G: enter_norm = 1'b1;
      S_SHIFT_P: begin
        state_next = S_SHIFT_G;
        c_next[9]  = add_sub;
        c_next[10] = add_2b;
      end
      S_SHIFT_G: begin
        state_next = S_ADD_P;
        c_next[8]  = (dig_reg != D_ZERO);
        c_next[9]  = add_sub;
        c_next[10] = add_2b;
      end
      S_ADD_P: state_next = S_ADD_G;
      S_ADD_G: begin
        if (iter_reg == LAST_ITER) begin
          state_next = S_CORR_P;
          c_next[8]  = p_sign;
          c_next[12] = p_sign;
        end else begin
          iter_next   = iter_reg + IW'(1);
          enter_shift = 1'b1;
        end
      end
      S_CORR_P: begin
        state_next = S_CORR_G;
        c_next[11] = 1'b1;
      end
      S_CORR_G: begin
        state_next = S_CONV_P;
        c_next[11] = 1'b1;
        c_next[13] = 1'b1;
      end
      S_CONV_P: state_next = S_CONV_G;
      S_CONV_G, S_DEN_G: enter_tail = 1'b1;
      S_DEN_P: state_next = S_DEN_G;
`ifdef SRT4_DIV_ZERO_EN
      S_ZERO_P: state_next = S_ZERO_G;
      S_ZERO_G: begin
        state_next = S_DONE;
        done_next  = 1'b1;
        err_next   = 1'b1;
      end
`endif
      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase

    // The final normalization decision doubles as the first SHIFT slot.
    if (enter_norm) begin
      if (norm_more) begin
        state_next = S_NORM_P;
        c_next[2]  = 1'b1;
        n_next     = n_reg + NCNT_W'(1);
      end else begin
        enter_shift = 1'b1;
      end
    end

    if (enter_shift) begin
      state_next = S_SHIFT_P;
      dig_next   = est_digit;
      c_next[3]  = 1'b1;
      c_next[4]  = (est_digit == D_P1);
      c_next[5]  = (est_digit == D_M1);
      c_next[6]  = (est_digit == D_M2);
      c_next[7]  = (est_digit == D_P2);
    end

    // n is consumed as the denormalization down-counter.
    if (enter_tail) begin
      if (n_reg != '0) begin
        state_next = S_DEN_P;
        c_next[14] = 1'b1;
        n_next     = n_reg - NCNT_W'(1);
      end else begin
        state_next = S_DONE;
        done_next  = 1'b1;
      end
    end
  end

  assign c0   = c_reg[0];
  assign c1   = c_reg[1];
  assign c2   = c_reg[2];
  assign c3   = c_reg[3];
  assign c4   = c_reg[4];
  assign c5   = c_reg[5];
  assign c6   = c_reg[6];
  assign c7   = c_reg[7];
  assign c8   = c_reg[8];
  assign c9   = c_reg[9];
  assign c10  = c_reg[10];
  assign c11  = c_reg[11];
  assign c12  = c_reg[12];
  assign c13  = c_reg[13];
  assign c14  = c_reg[14];
  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_srt4_control.sv
// Self-checking bench for srt4_control: per-cycle output traces compared against a slot-schedule model.
module tb_srt4_control;
  logic clk = 1'b0;
  logic rst_b, start, b_msb, b_zero, p_sign;
  logic [2:0] p_est;
  logic c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14;
  logic busy, done, err;

  always #5 clk = ~clk;

  srt4_control #(.ITERS(4), .NCNT_W(3)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .b_msb(b_msb), .b_zero(b_zero),
    .p_est(p_est), .p_sign(p_sign),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .c8(c8), .c9(c9), .c10(c10), .c11(c11), .c12(c12), .c13(c13), .c14(c14),
    .busy(busy), .done(done), .err(err)
  );

  int tests = 0;
  int fails = 0;
  logic [17:0] obs  [0:127];
  logic [17:0] expv [0:127];
  logic [2:0]  in_pe [0:127];
  logic        in_ps [0:127];
  logic [2:0]  dir_pe [0:3];
  logic        dir_ps;

  // {err, done, busy, c14..c0}
  function automatic logic [17:0] outw();
    return {err, done, busy, c14, c13, c12, c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic int digit_of(input logic [2:0] e);
    case (e)
      3'b001:         return 1;
      3'b010, 3'b011: return 2;
      3'b110:         return -1;
      3'b100, 3'b101: return -2;
      default:        return 0;
    endcase
  endfunction

  // Expected trace from the slot schedule: slot s pulses in cycle 1+2s, gaps in 2+2s.
  task automatic build_expected(input int n, input bit zero, input bit hold, output int dc);
    int s, cy, d;
    for (int i = 0; i < 128; i++) expv[i] = '0;
`ifdef SRT4_DIV_ZERO_EN
    if (zero) begin
      expv[1][1:0] = 2'b11;
      for (int i = 1; i <= 5; i++) expv[i][15] = 1'b1;
      expv[5][16] = 1'b1;
      for (int i = 5; i <= 7; i++) expv[i][17] = 1'b1;
      dc = 5;
      return;
    end
`endif
    if (zero) n = 7;
    expv[1][1:0] = 2'b11;
    s = 1;
    for (int k = 0; k < n; k++) begin expv[1 + 2 * s][2] = 1'b1; s++; end
    for (int i = 0; i < 4; i++) begin
      cy = 1 + 2 * s;
      d = digit_of(in_pe[cy]);
      expv[cy][3] = 1'b1;
      if (d == 1)  expv[cy][4] = 1'b1;
      if (d == -1) expv[cy][5] = 1'b1;
      if (d == -2) expv[cy][6] = 1'b1;
      if (d == 2)  expv[cy][7] = 1'b1;
      s++;
      cy = 1 + 2 * s;
      if (d != 0) expv[cy][8] = 1'b1;
      if (d > 0) begin expv[cy][9] = 1'b1; expv[cy - 1][9] = 1'b1; end
      if (d == 2 || d == -2) begin expv[cy][10] = 1'b1; expv[cy - 1][10] = 1'b1; end
      s++;
    end
    cy = 1 + 2 * s;
    if (in_ps[cy]) begin expv[cy][8] = 1'b1; expv[cy][12] = 1'b1; end
    s++;
    cy = 1 + 2 * s;
    expv[cy][11] = 1'b1; expv[cy - 1][11] = 1'b1; expv[cy][13] = 1'b1;
    s++;
    for (int k = 0; k < n; k++) begin expv[1 + 2 * s][14] = 1'b1; s++; end
    dc = 2 * s + 1;
    for (int i = 1; i <= dc; i++) expv[i][15] = 1'b1;
    expv[dc][16] = 1'b1;
    if (hold) begin expv[dc + 2][1:0] = 2'b11; expv[dc + 2][15] = 1'b1; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0; start = 1'b0; b_msb = 1'b0; b_zero = 1'b0; p_est = '0; p_sign = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // Start a division at edge 0 and capture outputs until two cycles after done.
  task automatic run_div(input int nt, input bit zero, input bit hold, input bit use_dir,
                         output int dc, output bit seen);
    int last, cn;
    for (int i = 0; i < 128; i++) begin obs[i] = 'x; in_pe[i] = '0; in_ps[i] = 1'b0; end
    @(negedge clk);
    start = 1'b1; b_zero = zero; b_msb = 1'b0; p_est = '0; p_sign = 1'b0;
    @(posedge clk);
    seen = 1'b0;
    last = 0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      obs[c] = outw();
      if (!hold) start = 1'b0;
      cn = c + 1;
      b_msb = !zero && (cn >= 3) && (((cn - 3) / 2) >= nt);
      p_est = 3'($urandom_range(0, 7));
      p_sign = 1'($urandom_range(0, 1));
      if (use_dir && cn >= 3 + 2 * nt && (cn - 3 - 2 * nt) / 4 < 4) p_est = dir_pe[(cn - 3 - 2 * nt) / 4];
      if (use_dir) p_sign = dir_ps;
      in_pe[cn] = p_est;
      in_ps[cn] = p_sign;
      if (!seen && obs[c][16] === 1'b1) begin seen = 1'b1; last = c + 2; end
      if (seen && c == last) break;
      @(posedge clk);
    end
    build_expected(nt, zero, hold, dc);
    $display("[TB] division nt=%0d zero=%0b hold=%0b done_seen=%0b expected done cycle %0d", nt, zero, hold, seen, dc);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_b = 1'b0; start = 1'b1; b_msb = 1'b1; b_zero = 1'b0; p_est = 3'b001; p_sign = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (outw() !== 18'h0) begin fails++; $display("FAIL reset_outputs[%0d]: got %h required 0", i, outw()); end
    end
    start = 1'b0; rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (outw() !== 18'h0) begin fails++; $display("FAIL reset_idle: got %h required 0", outw()); end
  endtask

  task automatic test_digits();
    int dc; bit seen;
    do_reset();
    dir_pe[0] = 3'b001; dir_pe[1] = 3'b010; dir_pe[2] = 3'b110; dir_pe[3] = 3'b000; dir_ps = 1'b0;
    run_div(0, 1'b0, 1'b0, 1'b1, dc, seen);
    tests++;
    if (!seen) begin fails++; $display("FAIL digits_timeout: no done observed"); end
    tests++;
    if (obs[23][16] !== 1'b1) begin fails++; $display("FAIL digits_done23: got %b required 1", obs[23][16]); end
    tests++;
    if (obs[3][7:3] !== 5'b00011) begin fails++; $display("FAIL digit_p1: got %b required 00011", obs[3][7:3]); end
    tests++;
    if (obs[7][7:3] !== 5'b10001) begin fails++; $display("FAIL digit_p2: got %b required 10001", obs[7][7:3]); end
    tests++;
    if (obs[11][7:3] !== 5'b00101) begin fails++; $display("FAIL digit_m1: got %b required 00101", obs[11][7:3]); end
    tests++;
    if (obs[15][7:3] !== 5'b00001) begin fails++; $display("FAIL digit_zero: got %b required 00001", obs[15][7:3]); end
    for (int c = 1; c <= dc + 2; c++) begin
      tests++;
      if (obs[c] !== expv[c]) begin fails++; $display("FAIL digits_trace cycle %0d: got %h required %h", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_norm();
    int dc, n2, n14; bit seen;
    do_reset();
    run_div(3, 1'b0, 1'b0, 1'b0, dc, seen);
    n2 = 0; n14 = 0;
    for (int c = 1; c <= 40; c++) begin n2 += int'(obs[c][2] === 1'b1); n14 += int'(obs[c][14] === 1'b1); end
    tests++;
    if (obs[35][16] !== 1'b1 || !seen) begin fails++; $display("FAIL norm_done35: got %b required 1", obs[35][16]); end
    tests++;
    if (obs[3][2] !== 1'b1 || obs[5][2] !== 1'b1 || obs[7][2] !== 1'b1 || n2 != 3)
      begin fails++; $display("FAIL norm_c2: got %0d pulses required 3 in cycles 3,5,7", n2); end
    tests++;
    if (n14 != 3) begin fails++; $display("FAIL norm_c14: got %0d pulses required 3", n14); end
    for (int c = 1; c <= dc + 2; c++) begin
      tests++;
      if (obs[c] !== expv[c]) begin fails++; $display("FAIL norm_trace cycle %0d: got %h required %h", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_corr();
    int dc, nt, cy; bit seen;
    for (int ps = 1; ps >= 0; ps--) begin
      do_reset();
      nt = $urandom_range(0, 7);
      for (int i = 0; i < 4; i++) dir_pe[i] = 3'($urandom_range(0, 7));
      dir_ps = 1'(ps);
      run_div(nt, 1'b0, 1'b0, 1'b1, dc, seen);
      cy = 19 + 2 * nt;
      tests++;
      if (obs[cy][12:8] !== ((ps == 1) ? 5'b10001 : 5'b00000))
        begin fails++; $display("FAIL corr_psign%0d: got %b required %b", ps, obs[cy][12:8], (ps == 1) ? 5'b10001 : 5'b00000); end
      for (int c = 1; c <= dc + 2; c++) begin
        tests++;
        if (obs[c] !== expv[c]) begin fails++; $display("FAIL corr_trace cycle %0d: got %h required %h", c, obs[c], expv[c]); end
      end
    end
  endtask

  task automatic test_random();
    int dc, nt; bit seen;
    for (int r = 0; r < 12; r++) begin
      do_reset();
      nt = $urandom_range(0, 7);
      run_div(nt, 1'b0, 1'b0, 1'b0, dc, seen);
      tests++;
      if (!seen || dc != 23 + 4 * nt) begin fails++; $display("FAIL random_done: seen %0b model %0d required %0d", seen, dc, 23 + 4 * nt); end
      for (int c = 1; c <= dc + 2; c++) begin
        tests++;
        if (obs[c] !== expv[c]) begin fails++; $display("FAIL random_trace run %0d cycle %0d: got %h required %h", r, c, obs[c], expv[c]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int dc, nt; bit seen;
    do_reset();
    @(negedge clk);
    start = 1'b1; b_msb = 1'b1; b_zero = 1'b0; p_est = 3'b001; p_sign = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    tests++;
    if (outw()[15:8] !== 8'b10000011) begin fails++; $display("FAIL midreset_add2: got %b required 10000011", outw()[15:8]); end
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (outw() !== 18'h0) begin fails++; $display("FAIL midreset_cleared: got %h required 0", outw()); end
    rst_b = 1'b1;
    nt = $urandom_range(0, 7);
    run_div(nt, 1'b0, 1'b0, 1'b0, dc, seen);
    tests++;
    if (!seen || obs[23 + 4 * nt][16] !== 1'b1) begin fails++; $display("FAIL midreset_rerun_done: seen %0b required done in cycle %0d", seen, 23 + 4 * nt); end
    for (int c = 1; c <= dc + 2; c++) begin
      tests++;
      if (obs[c] !== expv[c]) begin fails++; $display("FAIL midreset_trace cycle %0d: got %h required %h", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_back_to_back();
    int dc, nt, ndone; bit seen;
    do_reset();
    nt = $urandom_range(0, 7);
    run_div(nt, 1'b0, 1'b1, 1'b0, dc, seen);
    ndone = 0;
    for (int c = 1; c <= dc + 2; c++) ndone += int'(obs[c][16] === 1'b1);
    tests++;
    if (ndone != 1 || !seen) begin fails++; $display("FAIL hold_one_division: got %0d done pulses required 1", ndone); end
    for (int c = 1; c <= dc + 2; c++) begin
      tests++;
      if (obs[c] !== expv[c]) begin fails++; $display("FAIL hold_trace cycle %0d: got %h required %h", c, obs[c], expv[c]); end
    end
    do_reset();
  endtask

  task automatic test_div_zero();
    int dc; bit seen;
    do_reset();
    run_div(7, 1'b1, 1'b0, 1'b0, dc, seen);
`ifdef SRT4_DIV_ZERO_EN
    tests++;
    if (obs[5][17:16] !== 2'b11 || !seen) begin fails++; $display("FAIL zero_done5: got err,done=%b required 11", obs[5][17:16]); end
`else
    tests++;
    if (obs[51][17:16] !== 2'b01 || !seen) begin fails++; $display("FAIL zero_done51: got err,done=%b required 01", obs[51][17:16]); end
`endif
    for (int c = 1; c <= dc + 2; c++) begin
      tests++;
      if (obs[c] !== expv[c]) begin fails++; $display("FAIL zero_trace cycle %0d: got %h required %h", c, obs[c], expv[c]); end
    end
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; b_msb = 1'b0; b_zero = 1'b0; p_est = '0; p_sign = 1'b0;
    test_reset();
    test_digits();
    test_norm();
    test_corr();
    test_random();
    test_mid_reset();
    test_back_to_back();
    test_div_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/srt4_control.md
# srt4_control

Sequencer for the radix-4 SRT divider datapath (P, A, A′, B registers and the shared P±B/P±2B adder). On `start`, it steps the datapath through a fixed schedule: init and load, divisor normalization, four radix-4 iterations, sign correction, quotient conversion and remainder denormalization. Each datapath register is edge-triggered on its control lines, so every strobe this block drives is a registered, glitch-free, one-cycle pulse.

## Interface
- `ITERS`, 4: radix-4 iterations, one per quotient digit pair (8-bit quotient).
- `NCNT_W`, 3: width of the normalization shift counter.

- `clk` in 1: system clock; all state and outputs change on its rising edge.
- `rst_b` in 1: reset, synchronous, active-low.
- `start` in 1: begin a division; sampled only in IDLE.
- `b_msb` in 1: B[7].
- `b_zero` in 1: B == 0.
- `p_est` in 3: P[6:4], the bits that become P[8:6] after a 2-bit shift.
- `p_sign` in 1: P[8].
- `c0`…`c14` out 1 each: datapath strobes and levels as defined below.
- `busy` out 1: high from the cycle after `start` is accepted through the `done` cycle.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: divide-by-zero flag, held until the next accepted `start`.

## Operation
- All outputs are flop outputs. Reset value of every output is 0. Reset clears the stored shift count and the stored digit.
- **Slots.** Work is done in 2-cycle slots: a pulse cycle, then a gap cycle with all strobes low.
  - Status inputs are sampled at the edge that starts the pulse cycle.
  - The datapath updates on the strobe's rising edge, so its status is valid at the next slot.
- **Level lines** `c9` (subtract), `c10` (select 2B) and `c11` (adder ← A − A′) are high in the gap cycle before, and in the pulse cycle of, the strobe they qualify.
- **States:** IDLE → INIT → NORM → SHIFT/ADD ×ITERS → CORR → CONV → DENORM → DONE → IDLE.
- **INIT (1 slot):** pulse `c0` and `c1` together. This clears P and A′, loads A with the dividend and loads B with the divisor.
- **NORM:**
  - While `b_msb`=0 and count < 7: pulse `c2` and increment n.
  - Otherwise go to SHIFT. n is in the range 0..7.
- **SHIFT (1 slot per iteration):** choose digit d from `p_est`:
  - 000 or 111 → 0
  - 001 → +1
  - 010 or 011 → +2
  - 110 → −1
  - 100 or 101 → −2
  
  Pulse `c3` together with `c4` (+1), `c7` (+2), `c5` (−1) or `c6` (−2). No digit line is pulsed for d=0. Store d.
- **ADD (1 slot per iteration):** pulse `c8` with these levels:
  - +1: `c9`
  - +2: `c9` and `c10`
  - −1: none
  - −2: `c10`
  
  For d=0 the slot is consumed with no strobe.
- **CORR (1 slot):** if `p_sign`=1, pulse `c8` (P+B) and `c12` (A′+1). Otherwise the slot is idle.
- **CONV (1 slot):** `c11` level, pulse `c13`. A ← A − A′.
- **DENORM (n slots):** pulse `c14` n times.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Boundaries:**
  - `start` outside IDLE is ignored.
  - `rst_b`=0 at any edge, including mid-slot, forces IDLE with all outputs 0 at that edge.
  - At most one of `c4`–`c7` is high at any time.
  - `c8` and `c13` are never high together.

## Timing
- `start` is sampled at edge 0; the first pulse (INIT) is in cycle 1.
- Total slots S = 11 + 2n. Slot s has its pulse in cycle 1+2s and its gap in cycle 2+2s.
- `done` is in cycle 2S+1 = 23 + 4n: 23 for n=0, 51 for n=7.
- With `SRT4_DIV_ZERO_EN` and a zero divisor, `done` is in cycle 5.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `SRT4_DIV_ZERO_EN`:
  - **Defined:** `b_zero` is sampled at the first NORM decision (cycle 3). If it is 1, skip straight to DONE with `err`=1; no `c2`–`c14` pulses are issued.
  - **Undefined:** `b_zero` is ignored and `err` is tied 0. A zero divisor runs the full schedule with n=7, giving undefined results and `done` in cycle 51.

## Test plan
- B=0x80 (`b_msb`=1), `p_est`=001,010,110,000 across the four SHIFT slots. Expected:
  - `c3`+`c4`, `c3`+`c7`, `c3`+`c5`, then `c3` alone.
  - Matching `c8`/`c9`/`c10` patterns in the ADD slots.
  - `done` in cycle 23.
- `b_msb` held 0 for three NORM decisions, then 1. Expected: 3 `c2` pulses in cycles 3, 5, 7; 3 `c14` pulses; `done` in cycle 35.
- `p_sign`=1 at CORR. Expected: `c8` and `c12` pulsed together, and `c9`/`c10` low. Repeat with `p_sign`=0: no strobes in that slot.
- `rst_b` low during the second ADD pulse cycle. Expected: all outputs 0 at the next edge, `busy`=0, and a new `start` runs the full schedule with the correct timing.
- `start` held high for the entire run. Expected: exactly one division, with a second one beginning only in the cycle after `done`.
- `b_zero`=1 with the macro defined: `done` and `err`=1 in cycle 5. With the macro undefined: `err`=0 and `done` in cycle 51.
